control_unit_pipe: RTL and testbench

CONTROL_UNIT_PIPE -- requirements
Module: control_unit_pipe

---
 rtl/ctrl_pkg.sv | 53 +++++
 rtl/ctrl_decode.sv | 78 +++++++
 rtl/control_unit_pipe.sv | 127 ++++++++++++
 tb/tb_control_unit_pipe.sv | 308 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ctrl_pkg.sv
// ---------------------------------------------------------------------------
// ctrl_pkg
// Shared definitions for the RV32 control unit:
//   - major opcode constants (OP_*)
//   - alu_op encodings (ALU_MEM / ALU_BR / ALU_FN / ALU_M)
//   - ctrl_t, the packed control bundle carried by the output register
//   - helpers telling which source registers an opcode actually reads
// ---------------------------------------------------------------------------
package ctrl_pkg;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;

  // funct7 value that marks an R-type word as an RV32M multiply/divide
  localparam logic [6:0] F7_MULDIV = 7'b0000001;

  localparam logic [1:0] ALU_MEM = 2'b00;
  localparam logic [1:0] ALU_BR  = 2'b01;
  localparam logic [1:0] ALU_FN  = 2'b10;
  localparam logic [1:0] ALU_M   = 2'b11;

  typedef struct packed {
    logic       reg_write;
    logic       alu_src;
    logic       mem_write;
    logic       mem_read;
    logic       mem_to_reg;
    logic       branch;
    logic       jump;
    logic       illegal;
    logic [1:0] alu_op;
    logic [4:0] rd;
    logic [4:0] rs1;
    logic [4:0] rs2;
    logic [2:0] funct3;
    logic [6:0] funct7;
  } ctrl_t;

  function automatic logic reads_rs1(input logic [6:0] op);
    return (op == OP_R) || (op == OP_I) || (op == OP_LOAD) ||
           (op == OP_STORE) || (op == OP_BRANCH) || (op == OP_JALR);
  endfunction

  function automatic logic reads_rs2(input logic [6:0] op);
    return (op == OP_R) || (op == OP_STORE) || (op == OP_BRANCH);
  endfunction

endpackage

// File: rtl/ctrl_decode.sv
// ---------------------------------------------------------------------------
// ctrl_decode
// Purely combinational RV32 decoder. Maps one instruction word onto the
// control bundle; unknown opcodes produce illegal=1 with every control 0.
// Register/funct fields are always passed through from the word.
// Ports:
//   i_instr     [31:0] instruction word
//   o_ctrl      ctrl_t decoded control bundle
//   o_uses_rs1  instruction reads rs1
//   o_uses_rs2  instruction reads rs2
//   o_is_load   instruction is a load
// ---------------------------------------------------------------------------
module ctrl_decode
  import ctrl_pkg::*;
#(
  parameter bit ENABLE_M = 1'b0
) (
  input  logic [31:0] i_instr,
  output ctrl_t       o_ctrl,
  output logic        o_uses_rs1,
  output logic        o_uses_rs2,
  output logic        o_is_load
);

  logic [6:0] w_opcode;

  assign w_opcode   = i_instr[6:0];
  assign o_uses_rs1 = reads_rs1(w_opcode);
  assign o_uses_rs2 = reads_rs2(w_opcode);
  assign o_is_load  = (w_opcode == OP_LOAD);

  always_comb begin
    o_ctrl        = '0;
    o_ctrl.rd     = i_instr[11:7];
    o_ctrl.funct3 = i_instr[14:12];
    o_ctrl.rs1    = i_instr[19:15];
    o_ctrl.rs2    = i_instr[24:20];
    o_ctrl.funct7 = i_instr[31:25];
    case (w_opcode)
      OP_R: begin
        o_ctrl.reg_write = 1'b1;
        o_ctrl.alu_op    = (ENABLE_M && (i_instr[31:25] == F7_MULDIV)) ? ALU_M : ALU_FN;
      end
      OP_I: begin
        o_ctrl.reg_write = 1'b1;
        o_ctrl.alu_src   = 1'b1;
        o_ctrl.alu_op    = ALU_FN;
      end
      OP_LOAD: begin
        o_ctrl.reg_write  = 1'b1;
        o_ctrl.alu_src    = 1'b1;
        o_ctrl.mem_read   = 1'b1;
        o_ctrl.mem_to_reg = 1'b1;
        o_ctrl.alu_op     = ALU_MEM;
      end
      OP_STORE: begin
        o_ctrl.alu_src   = 1'b1;
        o_ctrl.mem_write = 1'b1;
        o_ctrl.alu_op    = ALU_MEM;
      end
      OP_BRANCH: begin
        o_ctrl.branch = 1'b1;
        o_ctrl.alu_op = ALU_BR;
      end
      OP_JAL: begin
        o_ctrl.reg_write = 1'b1;
        o_ctrl.jump      = 1'b1;
      end
      OP_JALR: begin
        o_ctrl.reg_write = 1'b1;
        o_ctrl.alu_src   = 1'b1;
        o_ctrl.jump      = 1'b1;
      end
      default: o_ctrl.illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/control_unit_pipe.sv
// ---------------------------------------------------------------------------
// control_unit_pipe
// One-stage registered RV32 control unit with valid/ready handshakes on both
// sides, a load-use interlock that inserts one bubble, a flush input and a
// saturating bubble counter.
// Ports:
//   clk, rst                 clock, asynchronous active-high reset
//   in_valid/in_ready        input handshake for instr[31:0]
//   flush                    drop held output and pending-load state
//   out_valid/out_ready      output handshake
//   reg_write..illegal       registered 1-bit controls
//   alu_op[1:0]              registered ALU class
//   rd, rs1, rs2, funct3, funct7  registered instruction fields
//   stall_count              bubbles inserted so far (saturating)
// ---------------------------------------------------------------------------
module control_unit_pipe
  import ctrl_pkg::*;
#(
  parameter bit          ENABLE_M      = 1'b0,
  parameter bit          ENABLE_HAZARD = 1'b1,
  parameter int unsigned STALL_CNT_W   = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [31:0]            instr,
  input  logic                   flush,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic                   reg_write,
  output logic                   alu_src,
  output logic                   mem_write,
  output logic                   mem_read,
  output logic                   mem_to_reg,
  output logic                   branch,
  output logic                   jump,
  output logic                   illegal,
  output logic [1:0]             alu_op,
  output logic [4:0]             rd,
  output logic [4:0]             rs1,
  output logic [4:0]             rs2,
  output logic [2:0]             funct3,
  output logic [6:0]             funct7,
  output logic [STALL_CNT_W-1:0] stall_count
);

  ctrl_t                  w_dec;
  logic                   w_uses_rs1;
  logic                   w_uses_rs2;
  logic                   w_is_load;
  logic                   w_slot_free;
  logic                   w_hazard;
  logic                   w_accept;

  ctrl_t                  r_ctrl;
  logic                   r_out_valid;
  logic                   r_load_pending;
  logic [4:0]             r_load_rd;
  logic [STALL_CNT_W-1:0] r_stall_cnt;

  ctrl_decode #(
    .ENABLE_M (ENABLE_M)
  ) u_decode (
    .i_instr    (instr),
    .o_ctrl     (w_dec),
    .o_uses_rs1 (w_uses_rs1),
    .o_uses_rs2 (w_uses_rs2),
    .o_is_load  (w_is_load)
  );

  assign w_slot_free = !r_out_valid || out_ready;

  // load_pending is only ever set for rd != 0, so x0 never interlocks
  assign w_hazard = ENABLE_HAZARD && r_load_pending && in_valid &&
                    ((w_uses_rs1 && (w_dec.rs1 == r_load_rd)) ||
                     (w_uses_rs2 && (w_dec.rs2 == r_load_rd)));

  // gated by rst so the handshake output also reads 0 during reset
  assign in_ready = !rst && w_slot_free && !w_hazard && !flush;
  assign w_accept = in_valid && in_ready;

  // Output register stage: accept, bubble, hold or drain
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_out_valid    <= 1'b0;
      r_ctrl         <= '0;
      r_load_pending <= 1'b0;
      r_load_rd      <= '0;
      r_stall_cnt    <= '0;
    end else if (flush) begin
      r_out_valid    <= 1'b0;
      r_load_pending <= 1'b0;
    end else if (w_slot_free) begin
      r_out_valid <= w_accept;
      if (w_accept) begin
        r_ctrl         <= w_dec;
        r_load_pending <= w_is_load && (w_dec.rd != 5'd0);
        r_load_rd      <= w_dec.rd;
      end else if (w_hazard) begin
        // bubble: the load result is available after this cycle
        r_load_pending <= 1'b0;
        if (r_stall_cnt != '1) begin
          r_stall_cnt <= r_stall_cnt + STALL_CNT_W'(1);
        end
      end
    end
  end

  assign out_valid   = r_out_valid;
  assign reg_write   = r_ctrl.reg_write;
  assign alu_src     = r_ctrl.alu_src;
  assign mem_write   = r_ctrl.mem_write;
  assign mem_read    = r_ctrl.mem_read;
  assign mem_to_reg  = r_ctrl.mem_to_reg;
  assign branch      = r_ctrl.branch;
  assign jump        = r_ctrl.jump;
  assign illegal     = r_ctrl.illegal;
  assign alu_op      = r_ctrl.alu_op;
  assign rd          = r_ctrl.rd;
  assign rs1         = r_ctrl.rs1;
  assign rs2         = r_ctrl.rs2;
  assign funct3      = r_ctrl.funct3;
  assign funct7      = r_ctrl.funct7;
  assign stall_count = r_stall_cnt;

endmodule

// File: tb/tb_control_unit_pipe.sv
// Two instances: #0 has RV32M decode, interlock on and a 3-bit stall counter;
// #1 has RV32M off, interlock off and the default 16-bit counter.
module tb_control_unit_pipe;
  import ctrl_pkg::*;

  localparam logic [31:0] I_ADD  = 32'h002081B3; // add x3,x1,x2
  localparam logic [31:0] I_LW   = 32'h0000A283; // lw  x5,0(x1)
  localparam logic [31:0] I_ADD6 = 32'h00228333; // add x6,x5,x2
  localparam logic [31:0] I_SW   = 32'h0020A023; // sw  x2,0(x1)
  localparam logic [31:0] I_ILL  = 32'h0000007F; // opcode 1111111
  localparam logic [31:0] I_MUL  = 32'h022083B3; // mul x7,x1,x2

  logic        clk;
  logic        rst;
  logic [1:0]  in_valid;
  logic [1:0]  flush;
  logic [1:0]  out_ready;
  logic [31:0] instr [2];
  wire  [1:0]  in_ready;
  wire  [1:0]  out_valid;
  wire  [34:0] v0, v1;
  wire  [2:0]  sc0;
  wire  [15:0] sc1;
  ctrl_t       d0, d1;

  assign d0 = ctrl_t'(v0);
  assign d1 = ctrl_t'(v1);

  control_unit_pipe #(.ENABLE_M(1'b1), .ENABLE_HAZARD(1'b1), .STALL_CNT_W(3)) dut0 (
    .clk(clk), .rst(rst), .in_valid(in_valid[0]), .in_ready(in_ready[0]), .instr(instr[0]),
    .flush(flush[0]), .out_valid(out_valid[0]), .out_ready(out_ready[0]),
    .reg_write(v0[34]), .alu_src(v0[33]), .mem_write(v0[32]), .mem_read(v0[31]),
    .mem_to_reg(v0[30]), .branch(v0[29]), .jump(v0[28]), .illegal(v0[27]),
    .alu_op(v0[26:25]), .rd(v0[24:20]), .rs1(v0[19:15]), .rs2(v0[14:10]),
    .funct3(v0[9:7]), .funct7(v0[6:0]), .stall_count(sc0)
  );

  control_unit_pipe #(.ENABLE_M(1'b0), .ENABLE_HAZARD(1'b0), .STALL_CNT_W(16)) dut1 (
    .clk(clk), .rst(rst), .in_valid(in_valid[1]), .in_ready(in_ready[1]), .instr(instr[1]),
    .flush(flush[1]), .out_valid(out_valid[1]), .out_ready(out_ready[1]),
    .reg_write(v1[34]), .alu_src(v1[33]), .mem_write(v1[32]), .mem_read(v1[31]),
    .mem_to_reg(v1[30]), .branch(v1[29]), .jump(v1[28]), .illegal(v1[27]),
    .alu_op(v1[26:25]), .rd(v1[24:20]), .rs1(v1[19:15]), .rs2(v1[14:10]),
    .funct3(v1[9:7]), .funct7(v1[6:0]), .stall_count(sc1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int    n_chk  = 0;
  int    n_fail = 0;
  ctrl_t q0 [$];
  ctrl_t q1 [$];

  // reference-model state (owned by the stimulus process)
  bit         pend [2];
  logic [4:0] prd  [2];
  int         sc_m [2];

  // monitor state (owned by the monitor process)
  bit    held   [2];
  ctrl_t held_d [2];
  bit    exp_v  [2];
  bit    have_v [2];

  task automatic check(input bit ok, input string name, input longint act, input longint exp);
    n_chk++;
    if (!ok) begin
      n_fail++;
      $display("FAIL %s: actual=%0h expected=%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic bit em_of(input int k);  return (k == 0); endfunction
  function automatic bit eh_of(input int k);  return (k == 0); endfunction
  function automatic int max_of(input int k); return (k == 0) ? 7 : 65535; endfunction
  function automatic int sc_of(input int k);  return (k == 0) ? int'(sc0) : int'(sc1); endfunction
  function automatic ctrl_t dout_of(input int k); return (k == 0) ? d0 : d1; endfunction
  function automatic int qsize(input int k);  return (k == 0) ? q0.size() : q1.size(); endfunction

  function automatic ctrl_t qpop(input int k);
    if (k == 0) return q0.pop_front();
    return q1.pop_front();
  endfunction

  task automatic qpush(input int k, input ctrl_t c);
    if (k == 0) q0.push_back(c); else q1.push_back(c);
  endtask

  // Reference decode written from the table as set membership per control.
  function automatic ctrl_t model_dec(input logic [31:0] w, input bit em);
    ctrl_t c;
    bit r, i, ld, st, br, jl, jr;
    r  = (w[6:0] == 7'h33); i  = (w[6:0] == 7'h13); ld = (w[6:0] == 7'h03);
    st = (w[6:0] == 7'h23); br = (w[6:0] == 7'h63); jl = (w[6:0] == 7'h6F);
    jr = (w[6:0] == 7'h67);
    c = '0;
    c.reg_write  = r | i | ld | jl | jr;
    c.alu_src    = i | ld | st | jr;
    c.mem_write  = st;
    c.mem_read   = ld;
    c.mem_to_reg = ld;
    c.branch     = br;
    c.jump       = jl | jr;
    c.illegal    = !(r | i | ld | st | br | jl | jr);
    if (r) c.alu_op = (em && w[31:25] == 7'b0000001) ? 2'b11 : 2'b10;
    else if (i) c.alu_op = 2'b10;
    else if (br) c.alu_op = 2'b01;
    else c.alu_op = 2'b00;
    c.rd = w[11:7]; c.funct3 = w[14:12]; c.rs1 = w[19:15]; c.rs2 = w[24:20]; c.funct7 = w[31:25];
    return c;
  endfunction

  function automatic bit model_reads(input logic [31:0] w, input logic [4:0] r);
    bit u1, u2;
    u1 = (w[6:0] inside {7'h33, 7'h13, 7'h03, 7'h23, 7'h63, 7'h67});
    u2 = (w[6:0] inside {7'h33, 7'h23, 7'h63});
    return (u1 && w[19:15] == r) || (u2 && w[24:20] == r);
  endfunction

  function automatic logic [31:0] rand_instr();
    logic [31:0] w;
    int sel;
    w = $urandom;
    w[11:7]  = 5'($urandom_range(0, 3));
    w[19:15] = 5'($urandom_range(0, 3));
    w[24:20] = 5'($urandom_range(0, 3));
    sel = $urandom_range(0, 9);
    case (sel)
      0: w[6:0] = 7'h33;
      1: w[6:0] = 7'h13;
      2, 3: w[6:0] = 7'h03;
      4: w[6:0] = 7'h23;
      5: w[6:0] = 7'h63;
      6: w[6:0] = 7'h6F;
      7: w[6:0] = 7'h67;
      8: w[6:0] = 7'h7F;
      default: ;
    endcase
    if (sel == 0 && $urandom_range(0, 1) == 1) w[31:25] = 7'b0000001;
    return w;
  endfunction

  // orm: 0 = out_ready held 1, 1 = random backpressure, 2 = leave as is
  task automatic roll(input int k, input int orm);
    if (orm == 0) out_ready[k] = 1'b1;
    else if (orm == 1) out_ready[k] = ($urandom_range(0, 2) != 0);
  endtask

  task automatic idle(input int k, input int n, input int orm);
    repeat (n) begin
      @(posedge clk); #1;
      roll(k, orm);
    end
  endtask

  // Present one instruction until accepted; expected response goes to the
  // scoreboard at the accepting cycle. With chk and out_ready stuck at 1 the
  // number of refused cycles is one for a flush plus one for a load-use bubble.
  task automatic issue(input int k, input logic [31:0] w, input bit do_flush,
                       input bit chk, input int orm);
    int waits;
    bit hz, done;
    int exp_w;
    if (do_flush) pend[k] = 1'b0;
    hz = eh_of(k) && pend[k] && model_reads(w, prd[k]);
    exp_w = (do_flush ? 1 : 0) + (hz ? 1 : 0);
    if (hz && sc_m[k] < max_of(k)) sc_m[k]++;
    in_valid[k] = 1'b1; instr[k] = w; flush[k] = do_flush;
    waits = 0; done = 1'b0;
    while (!done) begin
      @(negedge clk);
      if (in_valid[k] && in_ready[k]) begin
        qpush(k, model_dec(w, em_of(k)));
        check(sc_of(k) == sc_m[k], "stall_count", sc_of(k), sc_m[k]);
        if (chk) check(waits == exp_w, "accept_wait", waits, exp_w);
        done = 1'b1;
      end else if (waits >= 60) begin
        check(1'b0 == in_ready[k], "accept_timeout", waits, 60);
        done = 1'b1;
      end else begin
        waits++;
      end
      @(posedge clk); #1;
      flush[k] = 1'b0;
      roll(k, orm);
    end
    in_valid[k] = 1'b0;
    pend[k] = (w[6:0] == 7'h03) && (w[11:7] != 5'd0);
    prd[k]  = w[11:7];
  endtask

  task automatic mon_step(input int k);
    ctrl_t d, e;
    bit v, r, f;
    if (rst) begin
      if (k == 0) q0.delete(); else q1.delete();
      held[k] = 1'b0; have_v[k] = 1'b0;
      return;
    end
    v = out_valid[k]; r = out_ready[k]; f = flush[k]; d = dout_of(k);
    if (have_v[k]) check(v == exp_v[k], "out_valid", v, exp_v[k]);
    if (held[k]) check(d == held_d[k], "hold_stable", longint'(d), longint'(held_d[k]));
    if (v && r) begin
      check(qsize(k) != 0, "sb_unexpected_output", longint'(d), 0);
      if (qsize(k) != 0) begin
        e = qpop(k);
        check(d == e, "sb_data", longint'(d), longint'(e));
      end
    end else if (v && f && qsize(k) != 0) begin
      void'(qpop(k));
    end
    exp_v[k]  = (in_valid[k] && in_ready[k]) || (v && !r && !f);
    held[k]   = v && !r && !f;
    held_d[k] = d;
    have_v[k] = 1'b1;
  endtask

  always @(negedge clk) begin
    for (int k = 0; k < 2; k++) mon_step(k);
  end

  initial begin
    rst = 1'b1; in_valid = '0; flush = '0; out_ready = 2'b11;
    instr[0] = '0; instr[1] = '0;
    for (int k = 0; k < 2; k++) begin pend[k] = 0; prd[k] = '0; sc_m[k] = 0; end
    repeat (2) @(posedge clk);
    #1;
    for (int k = 0; k < 2; k++) begin
      check(out_valid[k] == 1'b0, "reset_out_valid", out_valid[k], 0);
      check(dout_of(k) == '0, "reset_outputs", longint'(dout_of(k)), 0);
      check(sc_of(k) == 0, "reset_stall_count", sc_of(k), 0);
    end
    @(posedge clk); #1;
    rst = 1'b0;

    for (int k = 0; k < 2; k++) begin
      issue(k, I_ADD, 0, 1, 0);
      issue(k, I_LW, 0, 1, 0);
      issue(k, I_ADD6, 0, 1, 0);          // bubble only where the interlock exists
      issue(k, I_ILL, 0, 1, 0);
      issue(k, I_MUL, 0, 1, 0);
      issue(k, I_LW, 0, 1, 0);
      issue(k, I_ADD6, 1, 1, 0);          // flush cancels the pending load
      idle(k, 2, 0);
      out_ready[k] = 1'b0;
      issue(k, I_SW, 0, 0, 2);
      repeat (3) begin
        @(negedge clk);
        check(in_ready[k] == 1'b0, "bp_in_ready", in_ready[k], 0);
        check(out_valid[k] == 1'b1, "bp_out_valid", out_valid[k], 1);
        check(dout_of(k).mem_write == 1'b1, "bp_mem_write", dout_of(k).mem_write, 1);
      end
      @(posedge clk); #1;
      out_ready[k] = 1'b1;
      idle(k, 2, 0);
      for (int n = 0; n < 120; n++) begin
        issue(k, rand_instr(), ($urandom_range(0, 7) == 0), 1, 0);
        idle(k, $urandom_range(0, 2), 0);
      end
      for (int n = 0; n < 150; n++) begin
        issue(k, rand_instr(), ($urandom_range(0, 7) == 0), 0, 1);
        idle(k, $urandom_range(0, 2), 1);
      end
      idle(k, 4, 0);
      check(qsize(k) == 0, "drain_empty", qsize(k), 0);
    end

    // drive the 3-bit counter of instance 0 past its ceiling
    for (int n = 0; n < 10; n++) begin
      issue(0, I_LW, 0, 1, 0);
      issue(0, I_ADD6, 0, 1, 0);
    end
    idle(0, 1, 0);
    check(sc_of(0) == 7, "stall_saturated", sc_of(0), 7);

    // asynchronous reset while both instances hold a store
    out_ready = 2'b00;
    issue(0, I_SW, 0, 0, 2);
    issue(1, I_SW, 0, 0, 2);
    #2;
    rst = 1'b1;
    #1;
    for (int k = 0; k < 2; k++) begin
      check(out_valid[k] == 1'b0, "async_rst_out_valid", out_valid[k], 0);
      check(dout_of(k) == '0, "async_rst_outputs", longint'(dout_of(k)), 0);
      check(sc_of(k) == 0, "async_rst_stall_count", sc_of(k), 0);
      check(in_ready[k] == 1'b0, "async_rst_in_ready", in_ready[k], 0);
      pend[k] = 0; sc_m[k] = 0;
    end
    @(posedge clk); #1;
    rst = 1'b0;
    out_ready = 2'b11;
    @(negedge clk);
    for (int k = 0; k < 2; k++)
      check(in_ready[k] == 1'b1, "post_rst_in_ready", in_ready[k], 1);
    for (int k = 0; k < 2; k++) begin
      @(posedge clk); #1;
      issue(k, I_ADD, 0, 1, 0);
      idle(k, 3, 0);
      check(qsize(k) == 0, "post_rst_drain", qsize(k), 0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
